// File: rtl/mdio_pkg.sv
// mdio_pkg: shared register addresses, speed codes,
// sequencer states and the per-PHY status bundle.
package mdio_pkg;

    localparam logic [4:0] REG_BMCR = 5'd0;
    localparam logic [4:0] REG_BMSR = 5'd1;

    localparam logic [1:0] SPD_NONE = 2'b00;
    localparam logic [1:0] SPD_10   = 2'b01;
    localparam logic [1:0] SPD_100  = 2'b10;
    localparam logic [1:0] SPD_1000 = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_WR,
        S_RD_BMSR,
        S_RD_STAT,
        S_WAIT,
        S_UPDATE
    } state_t;

    typedef enum logic [1:0] {
        OP_RST,
        OP_BMSR,
        OP_STAT
    } op_kind_t;

    typedef struct packed {
        logic       link;
        logic [1:0] spd;
        logic       dup;
    } phy_stat_t;

endpackage

// File: rtl/mdio_poll_ctrl_if.sv
// mdio_poll_ctrl_if: op handshake between the poll
// sequencer and the MDIO bit-level driver.
interface mdio_poll_ctrl_if;
    logic        op_exec;
    logic        op_rh_wl;
    logic [4:0]  op_phy_addr;
    logic [4:0]  op_addr;
    logic [15:0] op_wr_data;
    logic        op_done;
    logic [15:0] op_rd_data;
    logic        op_rd_ack;

    modport master (
        output op_exec, op_rh_wl, op_phy_addr,
        output op_addr, op_wr_data,
        input  op_done, op_rd_data, op_rd_ack
    );

    modport slave (
        input  op_exec, op_rh_wl, op_phy_addr,
        input  op_addr, op_wr_data,
        output op_done, op_rd_data, op_rd_ack
    );
endinterface

// File: rtl/mdio_status_decode.sv
// mdio_status_decode: BMSR + PHY status word to
// link/speed/duplex.
import mdio_pkg::*;

module mdio_status_decode (
    input  logic [15:0] bmsr,
    input  logic [15:0] stat,
    output phy_stat_t   st
);

    logic unused_bits;
    assign unused_bits = ^{bmsr[15:6], bmsr[4:3],
                           bmsr[1:0], stat[12:0]};

    // speed field remap; link needs BMSR link bits and a known speed
    always_comb begin
        st = '0;
        case (stat[15:14])
            2'b10:   st.spd = SPD_1000;
            2'b01:   st.spd = SPD_100;
            2'b00:   st.spd = SPD_10;
            default: st.spd = SPD_NONE;
        endcase
        st.link = bmsr[5] & bmsr[2] & (st.spd != SPD_NONE);
        st.dup  = stat[13];
    end

endmodule

// File: rtl/mdio_poll_ctrl.sv
// mdio_poll_ctrl: multi-PHY MDIO poll / soft-reset
// sequencer driving one driver transaction at a time.
import mdio_pkg::*;

module mdio_poll_ctrl #(
    parameter int unsigned NUM_PHY        = 1,
    parameter logic [4:0]  PHY_ADDR_BASE  = 5'h01,
    parameter int unsigned POLL_CYCLES    = 1_000_000,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter logic [15:0] RST_CTRL_VAL   = 16'h9140,
    parameter logic [4:0]  STAT_REG       = 5'h11
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PHY-1:0]   soft_rst_trig,
    mdio_poll_ctrl_if.master     op,
    output logic [NUM_PHY-1:0]   link_up,
    output logic [2*NUM_PHY-1:0] speed,
    output logic [NUM_PHY-1:0]   full_duplex,
    output logic                 link_chg,
    output logic                 op_timeout
);

    state_t             state, state_nxt;
    op_kind_t           kind;
    logic [NUM_PHY-1:0] sy1, sy2, sy3;
    logic [NUM_PHY-1:0] rst_pend, rst_set, rst_clr;
    logic [31:0]        tmr, wd;
    logic               tmr_tc, poll_pend, sweep_act;
    logic               sweep_start, rst_any, issue;
    logic [2:0]         idx, rst_sel, rst_low;
    logic               done_ev, wd_exp, ack_ok;
    logic               bmsr_good, wr_stat;
    logic [15:0]        bmsr_q;
    phy_stat_t          dec, nst, ost;

    mdio_status_decode u_dec (
        .bmsr (bmsr_q),
        .stat (op.op_rd_data),
        .st   (dec)
    );

    assign rst_set     = sy2 & ~sy3;
    assign tmr_tc      = (tmr == 32'(POLL_CYCLES - 1));
    assign sweep_start = (state == S_IDLE) && !rst_any
                         && poll_pend && !sweep_act;
    assign wd_exp      = (state == S_WAIT) && !op.op_done
                         && (wd == 32'(TIMEOUT_CYCLES));
    assign done_ev     = (state == S_WAIT)
                         && (op.op_done || wd_exp);
    assign ack_ok      = op.op_done && !op.op_rd_ack;
    assign bmsr_good   = ack_ok && op.op_rd_data[5]
                         && op.op_rd_data[2];
    assign wr_stat     = done_ev && ((kind == OP_STAT)
                         || (kind == OP_BMSR && !bmsr_good));
    assign nst         = (kind == OP_STAT && ack_ok) ? dec : '0;

    // lowest pending reset, reset-done clear mask, old status of idx
    always_comb begin
        rst_any = |rst_pend;
        rst_low = '0;
        rst_clr = '0;
        ost     = '0;
        for (int i = NUM_PHY - 1; i >= 0; i--) begin
            if (rst_pend[i]) rst_low = 3'(i);
        end
        for (int i = 0; i < NUM_PHY; i++) begin
            rst_clr[i] = done_ev && (kind == OP_RST)
                         && (rst_sel == 3'(i));
            if (idx == 3'(i)) begin
                ost.link = link_up[i];
                ost.spd  = speed[2*i +: 2];
                ost.dup  = full_duplex[i];
            end
        end
    end

    // trigger synchroniser and pending-reset flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sy1      <= '0;
            sy2      <= '0;
            sy3      <= '0;
            rst_pend <= '0;
        end else begin
            sy1      <= soft_rst_trig;
            sy2      <= sy1;
            sy3      <= sy2;
            rst_pend <= (rst_pend & ~rst_clr) | rst_set;
        end
    end

    // poll timer, sweep bookkeeping and watchdog
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr       <= '0;
            poll_pend <= 1'b0;
            sweep_act <= 1'b0;
            idx       <= '0;
            wd        <= '0;
        end else begin
            tmr       <= tmr_tc ? '0 : tmr + 32'd1;
            poll_pend <= tmr_tc | (poll_pend & ~sweep_start);
            wd        <= (state == S_WAIT) ? wd + 32'd1 : '0;
            if (sweep_start) sweep_act <= 1'b1;
            if (state == S_UPDATE) begin
                if (idx == 3'(NUM_PHY - 1)) begin
                    idx       <= '0;
                    sweep_act <= 1'b0;
                end else begin
                    idx <= idx + 3'd1;
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // FSM next state and issue strobe
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            S_IDLE: begin
                if (rst_any)
                    state_nxt = S_RST_WR;
                else if (poll_pend || sweep_act)
                    state_nxt = S_RD_BMSR;
            end
            S_RST_WR, S_RD_BMSR, S_RD_STAT: begin
                issue     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (done_ev) begin
                    if (kind == OP_RST)
                        state_nxt = S_IDLE;
                    else if (kind == OP_BMSR && bmsr_good)
                        state_nxt = S_RD_STAT;
                    else
                        state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // transaction request registers, held until the next issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op.op_exec     <= 1'b0;
            op.op_rh_wl    <= 1'b0;
            op.op_phy_addr <= PHY_ADDR_BASE;
            op.op_addr     <= '0;
            op.op_wr_data  <= '0;
            kind           <= OP_RST;
            rst_sel        <= '0;
        end else begin
            op.op_exec <= issue;
            if (state == S_IDLE && rst_any) rst_sel <= rst_low;
            if (state == S_RST_WR) begin
                op.op_rh_wl    <= 1'b0;
                op.op_phy_addr <= PHY_ADDR_BASE + {2'b00, rst_sel};
                op.op_addr     <= REG_BMCR;
                op.op_wr_data  <= RST_CTRL_VAL;
                kind           <= OP_RST;
            end
            if (state == S_RD_BMSR) begin
                op.op_rh_wl    <= 1'b1;
                op.op_phy_addr <= PHY_ADDR_BASE + {2'b00, idx};
                op.op_addr     <= REG_BMSR;
                kind           <= OP_BMSR;
            end
            if (state == S_RD_STAT) begin
                op.op_rh_wl <= 1'b1;
                op.op_addr  <= STAT_REG;
                kind        <= OP_STAT;
            end
        end
    end

    // per-PHY status, change pulse and sticky timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            link_up     <= '0;
            speed       <= '0;
            full_duplex <= '0;
            link_chg    <= 1'b0;
            op_timeout  <= 1'b0;
            bmsr_q      <= '0;
        end else begin
            link_chg   <= wr_stat && (nst != ost);
            op_timeout <= op_timeout | wd_exp;
            if (done_ev && kind == OP_BMSR)
                bmsr_q <= op.op_rd_data;
            if (wr_stat) begin
                for (int i = 0; i < NUM_PHY; i++) begin
                    if (idx == 3'(i)) begin
                        link_up[i]       <= nst.link;
                        speed[2*i +: 2]  <= nst.spd;
                        full_duplex[i]   <= nst.dup;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_poll_ctrl.sv
// tb_mdio_poll_ctrl: directed checks of the poll
// sequencer against a behavioural MDIO driver.
module tb_mdio_poll_ctrl;

    localparam int POLL = 300;
    localparam int TMO  = 20;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] soft_rst_trig;
    logic [1:0] link_up;
    logic [3:0] speed;
    logic [1:0] full_duplex;
    logic       link_chg;
    logic       op_timeout;

    mdio_poll_ctrl_if bus ();

    mdio_poll_ctrl #(
        .NUM_PHY        (2),
        .PHY_ADDR_BASE  (5'h01),
        .POLL_CYCLES    (POLL),
        .TIMEOUT_CYCLES (TMO),
        .RST_CTRL_VAL   (16'h9140),
        .STAT_REG       (5'h11)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .soft_rst_trig (soft_rst_trig),
        .op            (bus),
        .link_up       (link_up),
        .speed         (speed),
        .full_duplex   (full_duplex),
        .link_chg      (link_chg),
        .op_timeout    (op_timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int chg_cnt = 0;
    int txn_cnt = 0;

    logic [15:0] bmsr_v [2];
    logic [15:0] stat_v [2];
    logic [1:0]  nack;
    logic [1:0]  noresp;

    logic [4:0]  log_phy [64];
    logic [4:0]  log_reg [64];
    logic        log_rh  [64];
    logic [15:0] log_wd  [64];
    int          log_cyc [64];

    logic        pend;
    int          dly;
    logic [4:0]  cur_phy, cur_reg;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n && link_chg) chg_cnt++;
    end

    // behavioural driver: op_done three cycles after op_exec
    always @(negedge clk) begin
        int p;
        if (!rst_n) begin
            pend = 1'b0;
            dly = 0;
            bus.op_done = 1'b0;
            bus.op_rd_data = '0;
            bus.op_rd_ack = 1'b0;
        end else begin
            bus.op_done = 1'b0;
            if (pend) begin
                dly--;
                if (dly == 0) begin
                    pend = 1'b0;
                    bus.op_done = 1'b1;
                    chk("hold_phy", 32'(bus.op_phy_addr), 32'(cur_phy));
                    chk("hold_reg", 32'(bus.op_addr), 32'(cur_reg));
                    p = int'(cur_phy) - 1;
                    bus.op_rd_data = '0;
                    bus.op_rd_ack = 1'b0;
                    if (p >= 0 && p < 2) begin
                        if (cur_reg == 5'h01) begin
                            bus.op_rd_data = bmsr_v[p];
                            bus.op_rd_ack = nack[p];
                        end else if (cur_reg == 5'h11) begin
                            bus.op_rd_data = stat_v[p];
                        end
                    end
                end
            end
            if (bus.op_exec) begin
                if (txn_cnt < 64) begin
                    log_phy[txn_cnt] = bus.op_phy_addr;
                    log_reg[txn_cnt] = bus.op_addr;
                    log_rh[txn_cnt]  = bus.op_rh_wl;
                    log_wd[txn_cnt]  = bus.op_wr_data;
                    log_cyc[txn_cnt] = cyc;
                end
                txn_cnt++;
                cur_phy = bus.op_phy_addr;
                cur_reg = bus.op_addr;
                p = int'(cur_phy) - 1;
                if (!(p >= 0 && p < 2 && noresp[p])) begin
                    pend = 1'b1;
                    dly = 3;
                end
            end
        end
    end

    task automatic wait_txn(input int n);
        int k;
        k = 0;
        while (txn_cnt < n && k < 3000) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (txn_cnt < n) chk("wait_txn", 32'(txn_cnt), 32'(n));
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #2;
    endtask

    task automatic chk_txn(input string tag, input int i,
                           input logic [4:0] phy,
                           input logic [4:0] rg,
                           input logic rh);
        chk(tag, {log_rh[i], 3'b0, log_phy[i], 3'b0, log_reg[i]},
                 {rh, 3'b0, phy, 3'b0, rg});
    endtask

    initial begin
        int d;
        rst_n = 1'b0;
        soft_rst_trig = '0;
        nack = '0;
        noresp = '0;
        bmsr_v[0] = 16'h0024;
        bmsr_v[1] = 16'h0024;
        stat_v[0] = 16'hA000;
        stat_v[1] = 16'hA000;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_exec", 32'(bus.op_exec), 0);
        chk("rst_rhwl", 32'(bus.op_rh_wl), 0);
        chk("rst_phy", 32'(bus.op_phy_addr), 1);
        chk("rst_addr", 32'(bus.op_addr), 0);
        chk("rst_wdat", 32'(bus.op_wr_data), 0);
        chk("rst_stat", {link_up, speed, full_duplex,
                         link_chg, op_timeout}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        wait_txn(4);
        settle();
        chk_txn("t0_bmsr", 0, 5'h01, 5'h01, 1'b1);
        chk_txn("t1_stat", 1, 5'h01, 5'h11, 1'b1);
        chk_txn("t2_bmsr", 2, 5'h02, 5'h01, 1'b1);
        chk("s1_link", 32'(link_up), 32'h3);
        chk("s1_speed", 32'(speed), 32'hF);
        chk("s1_dup", 32'(full_duplex), 32'h3);
        chk("s1_chg", 32'(chg_cnt), 2);
        chk("s1_tmo", 32'(op_timeout), 0);

        wait_txn(8);
        settle();
        chk("s2_chg", 32'(chg_cnt), 2);

        nack[1] = 1'b1;
        wait_txn(11);
        settle();
        chk_txn("nk_p1", 10, 5'h02, 5'h01, 1'b1);
        chk("nk_link", 32'(link_up), 32'h1);
        chk("nk_speed", 32'(speed), 32'h3);
        chk("nk_dup", 32'(full_duplex), 32'h1);
        chk("nk_chg", 32'(chg_cnt), 3);

        nack[1] = 1'b0;
        stat_v[0] = 16'h4000;
        wait_txn(15);
        settle();
        chk("sa_speed", 32'(speed), 32'hE);
        chk("sa_dup", 32'(full_duplex), 32'h2);
        chk("sa_link", 32'(link_up), 32'h3);
        chk("sa_chg", 32'(chg_cnt), 5);

        stat_v[0] = 16'h0000;
        wait_txn(19);
        settle();
        chk("sb_speed", 32'(speed), 32'hD);
        chk("sb_chg", 32'(chg_cnt), 6);

        wait_txn(23);
        settle();
        chk("sc_speed", 32'(speed), 32'hD);
        chk("sc_chg", 32'(chg_cnt), 6);

        wait_txn(24);
        soft_rst_trig = 2'b10;
        repeat (4) @(posedge clk);
        #2;
        soft_rst_trig = 2'b00;
        wait_txn(28);
        settle();
        chk_txn("sr_p0st", 24, 5'h01, 5'h11, 1'b1);
        chk_txn("sr_wr", 25, 5'h02, 5'h00, 1'b0);
        chk("sr_wdat", 32'(log_wd[25]), 32'h9140);
        chk_txn("sr_res", 26, 5'h02, 5'h01, 1'b1);
        chk_txn("sr_res2", 27, 5'h02, 5'h11, 1'b1);
        chk("sr_speed", 32'(speed), 32'hD);
        chk("sr_chg", 32'(chg_cnt), 6);

        noresp[0] = 1'b1;
        wait_txn(29);
        noresp[0] = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        chk("to_early", 32'(op_timeout), 0);
        wait_txn(30);
        settle();
        chk("to_flag", 32'(op_timeout), 1);
        chk("to_link0", 32'(link_up[0]), 0);
        chk("to_spd0", 32'(speed[1:0]), 0);
        chk_txn("to_next", 29, 5'h02, 5'h01, 1'b1);
        wait_txn(31);
        settle();

        wait_txn(32);
        rst_n = 1'b0;
        #1;
        chk("ar_exec", 32'(bus.op_exec), 0);
        chk("ar_phy", 32'(bus.op_phy_addr), 1);
        chk("ar_stat", {link_up, speed, full_duplex,
                        link_chg, op_timeout}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        d = cyc;
        wait_txn(33);
        d = log_cyc[32] - d;
        chk("ar_lat", 32'(d >= POLL && d <= POLL + 4), 1);
        chk_txn("ar_first", 32, 5'h01, 5'h01, 1'b1);
        settle();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
